// File: rtl/hazard_stall_unit.sv
// D-stage hazard detection: tracks {dest, Tnew} for E/M/W, raises stall when a
// source is not ready by its Tuse, and produces D-stage forward selects.
module hazard_stall_unit #(
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rs_d,
  input  logic [AW-1:0]    rt_d,
  input  logic [1:0]       tuse_rs,
  input  logic [1:0]       tuse_rt,
  input  logic [AW-1:0]    a3_d,
  input  logic [1:0]       tnew_d,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [AW-1:0]    a3_e,
  output logic [AW-1:0]    a3_m,
  output logic [AW-1:0]    a3_w,
  output logic [1:0]       tnew_e,
  output logic [1:0]       tnew_m,
  output logic [1:0]       tnew_w,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_NONE = 2'd3;
  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_E     = 2'd1;
  localparam logic [1:0] SEL_M     = 2'd2;
  localparam logic [1:0] SEL_W     = 2'd3;

  logic [AW-1:0]    a3_e_q, a3_e_d, a3_m_q, a3_m_d, a3_w_q, a3_w_d;
  logic [1:0]       tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d, tnew_w_q, tnew_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [AW-1:0]    a3_rec;
  logic [1:0]       tnew_rec;
  logic             stall_rs, stall_rt;

  // Tnew decrements as the instruction moves down; stays at 0 once ready.
  function automatic logic [1:0] age(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic src_stall(
    input logic [AW-1:0] src,  input logic [1:0] tuse,
    input logic [AW-1:0] ae,   input logic [1:0] te,
    input logic [AW-1:0] am,   input logic [1:0] tm
  );
    return (tuse != TUSE_NONE) && (src != '0) &&
           (((ae == src) && (te > tuse)) || ((am == src) && (tm > tuse)));
  endfunction

  // Nearest producing stage wins; a bubble (dest 0) never matches a nonzero source.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic [AW-1:0] ae, input logic [1:0] te,
    input logic [AW-1:0] am, input logic [1:0] tm,
    input logic [AW-1:0] aw
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (src != '0) begin
      if ((ae == src) && (te == 2'd0))      sel = SEL_E;
      else if ((am == src) && (tm == 2'd0)) sel = SEL_M;
      else if (aw == src)                   sel = SEL_W;
    end
    return sel;
  endfunction

  always_comb begin
    a3_rec   = ((tnew_d == TNEW_NONE) || (a3_d == '0)) ? '0 : a3_d;
    tnew_rec = (a3_rec == '0) ? 2'd0 : tnew_d;
  end

  always_comb begin
    stall_rs = src_stall(rs_d, tuse_rs, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall_rt = src_stall(rt_d, tuse_rt, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall    = stall_rs | stall_rt;
    fwd_rs_d = fwd_sel(rs_d, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    fwd_rt_d = fwd_sel(rt_d, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
  end

  // A stalled D instruction leaves a bubble in E.
  always_comb begin
    a3_e_d      = stall ? '0 : a3_rec;
    tnew_e_d    = stall ? 2'd0 : tnew_rec;
    a3_m_d      = a3_e_q;
    tnew_m_d    = age(tnew_e_q);
    a3_w_d      = a3_m_q;
    tnew_w_d    = age(tnew_m_q);
    stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a3_e_q      <= '0;
      a3_m_q      <= '0;
      a3_w_q      <= '0;
      tnew_e_q    <= 2'd0;
      tnew_m_q    <= 2'd0;
      tnew_w_q    <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      a3_e_q      <= a3_e_d;
      a3_m_q      <= a3_m_d;
      a3_w_q      <= a3_w_d;
      tnew_e_q    <= tnew_e_d;
      tnew_m_q    <= tnew_m_d;
      tnew_w_q    <= tnew_w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign a3_e      = a3_e_q;
  assign a3_m      = a3_m_q;
  assign a3_w      = a3_w_q;
  assign tnew_e    = tnew_e_q;
  assign tnew_m    = tnew_m_q;
  assign tnew_w    = tnew_w_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: per-cycle vector table checked through a queue,
// plus a bounded hand-written load-use stall sequence.
module tb_hazard_stall_unit;

  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [AW-1:0]    rs_d, rt_d, a3_d;
  logic [1:0]       tuse_rs, tuse_rt, tnew_d;
  logic             stall;
  logic [1:0]       fwd_rs_d, fwd_rt_d;
  logic [AW-1:0]    a3_e, a3_m, a3_w;
  logic [1:0]       tnew_e, tnew_m, tnew_w;
  logic [CNT_W-1:0] stall_cnt;

  hazard_stall_unit #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .a3_d(a3_d), .tnew_d(tnew_d),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .a3_e(a3_e), .a3_m(a3_m), .a3_w(a3_w),
    .tnew_e(tnew_e), .tnew_m(tnew_m), .tnew_w(tnew_w),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int st, frs, frt, a3e, tne, a3m, tnm, a3w, tnw, cnt;
  } exp_t;

  typedef struct {
    int   rst, rs, rt, tus, tut, a3, tn;
    bit   chk;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(int rst, int rs, int rt, int tus, int tut, int a3, int tn,
                             bit chk, int st, int frs, int frt, int a3e, int tne,
                             int a3m, int tnm, int a3w, int tnw, int cnt);
    vec_t r;
    r.rst = rst; r.rs = rs; r.rt = rt; r.tus = tus; r.tut = tut; r.a3 = a3; r.tn = tn;
    r.chk = chk;
    r.e.row = 0; r.e.st = st; r.e.frs = frs; r.e.frt = frt;
    r.e.a3e = a3e; r.e.tne = tne; r.e.a3m = a3m; r.e.tnm = tnm;
    r.e.a3w = a3w; r.e.tnw = tnw; r.e.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input int want);
    total++;
    if (act !== 32'(want)) begin
      bad++;
      $display("FAIL %s row=%0d got=%0d want=%0d", nm, row, act, want);
    end
  endtask

  task automatic drive(input vec_t t);
    reset   = t.rst[0];
    rs_d    = AW'(t.rs);
    rt_d    = AW'(t.rt);
    tuse_rs = 2'(t.tus);
    tuse_rt = 2'(t.tut);
    a3_d    = AW'(t.a3);
    tnew_d  = 2'(t.tn);
  endtask

  // Each row: inputs for that cycle, outputs expected during that cycle.
  task automatic build_table();
    // reset, then idle
    tbl.push_back(v(1, 0, 0, 3, 3, 0, 3,  0, 0,0,0, 0,0, 0,0, 0,0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 0,0, 0,0, 0,0, 0));
    // lw r8 then beq r8: two stalls, then W forward
    tbl.push_back(v(0, 0, 0, 3, 3, 8, 2,  1, 0,0,0, 0,0, 0,0, 0,0, 0));
    tbl.push_back(v(0, 8, 0, 0, 3, 0, 3,  1, 1,0,0, 8,2, 0,0, 0,0, 0));
    tbl.push_back(v(0, 8, 0, 0, 3, 0, 3,  1, 1,0,0, 0,0, 8,1, 0,0, 1));
    tbl.push_back(v(0, 8, 0, 0, 3, 0, 3,  1, 0,3,0, 0,0, 0,0, 8,0, 2));
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 0,0, 0,0, 0,0, 2));
    // addu r9 then sw r9: no stall, M forward one cycle later
    tbl.push_back(v(0, 0, 0, 3, 3, 9, 1,  1, 0,0,0, 0,0, 0,0, 0,0, 2));
    tbl.push_back(v(0, 9, 0, 1, 3, 0, 3,  1, 0,0,0, 9,1, 0,0, 0,0, 2));
    tbl.push_back(v(0, 9, 0, 1, 3, 0, 3,  1, 0,2,0, 0,0, 9,0, 0,0, 2));
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 0,0, 0,0, 9,0, 2));
    // jal r31 then jr r31: E forward
    tbl.push_back(v(0, 0, 0, 3, 3, 31, 0, 1, 0,0,0, 0,0, 0,0, 0,0, 2));
    tbl.push_back(v(0, 31, 0, 0, 3, 0, 3, 1, 0,1,0, 31,0, 0,0, 0,0, 2));
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 0,0, 31,0, 0,0, 2));
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 0,0, 0,0, 31,0, 2));
    // write to r0 is a bubble; reading r0 never stalls/forwards
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 1,  1, 0,0,0, 0,0, 0,0, 0,0, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 3,  1, 0,0,0, 0,0, 0,0, 0,0, 2));
    // lw r10 then addu using rt=r10 (tuse 1): one stall on the rt path
    tbl.push_back(v(0, 0, 0, 3, 3, 10, 2, 1, 0,0,0, 0,0, 0,0, 0,0, 2));
    tbl.push_back(v(0, 3, 10, 1, 1, 11, 1,1, 1,0,0, 10,2, 0,0, 0,0, 2));
    tbl.push_back(v(0, 3, 10, 1, 1, 11, 1,1, 0,0,0, 0,0, 10,1, 0,0, 3));
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 11,1, 0,0, 10,0, 3));
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 0,0, 11,0, 0,0, 3));
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 0,0, 0,0, 11,0, 3));
    // two back-to-back writers of r5: nearest stage wins on both sources
    tbl.push_back(v(0, 0, 0, 3, 3, 5, 0,  1, 0,0,0, 0,0, 0,0, 0,0, 3));
    tbl.push_back(v(0, 5, 5, 0, 3, 5, 0,  1, 0,1,1, 5,0, 0,0, 0,0, 3));
    tbl.push_back(v(0, 5, 5, 0, 0, 0, 3,  1, 0,1,1, 5,0, 5,0, 0,0, 3));
    tbl.push_back(v(0, 5, 5, 0, 0, 0, 3,  1, 0,2,2, 0,0, 5,0, 5,0, 3));
    tbl.push_back(v(0, 5, 5, 0, 0, 0, 3,  1, 0,3,3, 0,0, 0,0, 5,0, 3));
    // reset asserted in the middle of a load-use stall
    tbl.push_back(v(0, 0, 0, 3, 3, 8, 2,  1, 0,0,0, 0,0, 0,0, 0,0, 3));
    tbl.push_back(v(0, 8, 0, 0, 3, 0, 3,  1, 1,0,0, 8,2, 0,0, 0,0, 3));
    tbl.push_back(v(1, 8, 0, 0, 3, 0, 3,  1, 1,0,0, 0,0, 8,1, 0,0, 4));
    tbl.push_back(v(0, 8, 0, 0, 3, 0, 3,  1, 0,0,0, 0,0, 0,0, 0,0, 0));
    tbl.push_back(v(0, 0, 0, 3, 3, 0, 3,  1, 0,0,0, 0,0, 0,0, 0,0, 0));
  endtask

  initial begin
    exp_t e;
    vec_t idle;
    int   nst;
    bit   done;

    idle = v(1, 0, 0, 3, 3, 0, 3, 0, 0,0,0, 0,0, 0,0, 0,0, 0);
    drive(idle);
    build_table();

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      if (tbl[i].chk) begin
        e = tbl[i].e;
        e.row = i;
        sb.push_back(e);
      end
      #2;
      if (tbl[i].chk) begin
        e = sb.pop_front();
        chk("stall",    e.row, 32'(stall),     e.st);
        chk("fwd_rs_d", e.row, 32'(fwd_rs_d),  e.frs);
        chk("fwd_rt_d", e.row, 32'(fwd_rt_d),  e.frt);
        chk("a3_e",     e.row, 32'(a3_e),      e.a3e);
        chk("tnew_e",   e.row, 32'(tnew_e),    e.tne);
        chk("a3_m",     e.row, 32'(a3_m),      e.a3m);
        chk("tnew_m",   e.row, 32'(tnew_m),    e.tnm);
        chk("a3_w",     e.row, 32'(a3_w),      e.a3w);
        chk("tnew_w",   e.row, 32'(tnew_w),    e.tnw);
        chk("stall_cnt", e.row, 32'(stall_cnt), e.cnt);
      end
    end

    // lw r12 then beq r12: count stall cycles until release (bounded)
    @(negedge clk);
    drive(v(0, 0, 0, 3, 3, 12, 2, 0, 0,0,0, 0,0, 0,0, 0,0, 0));
    @(negedge clk);
    drive(v(0, 12, 0, 0, 3, 0, 3, 0, 0,0,0, 0,0, 0,0, 0,0, 0));
    nst  = 0;
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      #2;
      if (stall === 1'b1) begin
        nst++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL lw_beq_timeout stall still high after 8 cycles");
    end else begin
      chk("lw_beq_stall_cycles", 100, 32'(nst), 2);
      chk("lw_beq_fwd_rs_d",     100, 32'(fwd_rs_d), 3);
      chk("lw_beq_stall_cnt",    100, 32'(stall_cnt), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
